// File: rtl/tile_match_controller.sv
// Memory-match game controller for a 10-tile board: selection, compare timing, scoring.
// Optional define TILE_BLINK_EN blinks the two selected lamps while a pair is on show.
module tile_match_controller #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int NUM_PAIRS    = 5
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       quit,
  input  logic [9:0] SW,
  output logic [3:0] tile_idx,
  input  logic [2:0] tile_color,
  output logic [9:0] LEDR,
  output logic [1:0] mode,
  output logic [7:0] moves,
  output logic       all_matched
);
  localparam int TW = $clog2(BLINK_CYCLES + 1);
  localparam int PW = $clog2(NUM_PAIRS + 1);

  typedef enum logic [2:0] {S_MENU, S_IDLE, S_ONE, S_SHOW, S_END} state_t;

  state_t          state, state_d;
  logic [9:0]      sw_q, matched, elig, evt, first_oh, second_oh, led_d;
  logic [PW-1:0]   pair_cnt;
  logic [TW-1:0]   timer;
  logic [3:0]      first, second;
  logic [2:0]      c1, c2;
  logic            sel_vld, clr, ld_first, ld_second, hit, quit_go, blink_on;

  assign first_oh    = 10'd1 << first;
  assign second_oh   = 10'd1 << second;
  assign evt         = SW & ~sw_q & ~matched;
  assign mode        = (state == S_MENU) ? 2'd0 : (state == S_END) ? 2'd2 : 2'd1;
  assign all_matched = (state == S_END);

  // Only the current state's eligible rising edges compete; the re-pressed first tile is masked.
  always_comb begin
    case (state)
      S_IDLE:  elig = evt;
      S_ONE:   elig = evt & ~first_oh;
      default: elig = '0;
    endcase
  end

  always_comb begin
    sel_vld  = 1'b0;
    tile_idx = '0;
    for (int i = 9; i >= 0; i--) begin
      if (elig[i]) begin
        sel_vld  = 1'b1;
        tile_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d   = state;
    clr       = 1'b0;
    ld_first  = 1'b0;
    ld_second = 1'b0;
    hit       = 1'b0;
    quit_go   = 1'b0;
    case (state)
      S_MENU: if (start) begin
        clr     = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: if (sel_vld) begin
        ld_first = 1'b1;
        state_d  = S_ONE;
      end
      S_ONE: if (sel_vld) begin
        ld_second = 1'b1;
        state_d   = S_SHOW;
      end
      S_SHOW: if (timer == '0) begin
        if (c1 == c2) begin
          hit     = 1'b1;
          state_d = (pair_cnt == PW'(NUM_PAIRS - 1)) ? S_END : S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_END:   ;
      default: state_d = S_MENU;
    endcase
    // Abandoning the game overrides whatever else this cycle would have done.
    if (quit && state != S_MENU) begin
      state_d   = S_MENU;
      quit_go   = 1'b1;
      ld_first  = 1'b0;
      ld_second = 1'b0;
      hit       = 1'b0;
    end
  end

  always_comb begin
    case (state)
      S_MENU:  led_d = '0;
      S_END:   led_d = '1;
      S_ONE:   led_d = matched | first_oh;
      S_SHOW:  led_d = matched | (blink_on ? (first_oh | second_oh) : 10'd0);
      default: led_d = matched;
    endcase
    if (quit_go || clr) led_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_MENU;
      sw_q     <= '0;
      matched  <= '0;
      pair_cnt <= '0;
      moves    <= '0;
      timer    <= '0;
      first    <= '0;
      second   <= '0;
      c1       <= '0;
      c2       <= '0;
      LEDR     <= '0;
    end else begin
      state <= state_d;
      sw_q  <= SW;
      LEDR  <= led_d;
      if (clr) begin
        matched  <= '0;
        pair_cnt <= '0;
        moves    <= '0;
      end
      if (ld_first) begin
        first <= tile_idx;
        c1    <= tile_color;
      end
      if (ld_second) begin
        second <= tile_idx;
        c2     <= tile_color;
        if (moves != 8'hFF) moves <= moves + 8'd1;
      end
      if (hit) begin
        matched  <= matched | first_oh | second_oh;
        pair_cnt <= pair_cnt + PW'(1);
      end
      if (quit_go)                           timer <= '0;
      else if (ld_second)                    timer <= TW'(BLINK_CYCLES - 1);
      else if (state == S_SHOW && timer != '0) timer <= timer - TW'(1);
    end
  end

`ifdef TILE_BLINK_EN
  localparam int BLINK_HALF = (BLINK_CYCLES / 8 > 0) ? BLINK_CYCLES / 8 : 1;
  localparam int BW         = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (ld_second) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (state == S_SHOW) begin
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  assign blink_on = 1'b1;
`endif
endmodule
